// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock show-ahead FIFO with level, thresholds, flush and sticky errors
module sync_fifo_flags #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  flush,
  input  logic                  wEn,
  input  logic [DATA_WIDTH-1:0] wData,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rEn,
  output logic [DATA_WIDTH-1:0] rData,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = LW'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = LW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_full  = (r_level == LP_DEPTH);
  assign w_empty = (r_level == '0);

  // Flush masks both requests so that cycle neither moves data nor raises errors.
  assign w_rd_acc  = ~flush & rEn & ~w_empty;
  assign w_wr_acc  = ~flush & wEn & (~w_full | w_rd_acc);
  assign w_ovf_set = ~flush & wEn & ~w_wr_acc;
  assign w_udf_set = ~flush & rEn & w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= wData;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + ADDR_WIDTH'(w_wr_acc);
      r_rptr  <= r_rptr + ADDR_WIDTH'(w_rd_acc);
      r_level <= r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
    end
  end

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_set) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_level >= LP_AFULL);
  assign almost_empty = (r_level <= LP_AEMPTY);
  assign level        = r_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign rData        = r_mem[r_rptr];

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - vector table, corner sequences and randomized queue-model check for sync_fifo_flags
module tb_sync_fifo_flags;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wEn = 1'b0;
  logic          rEn = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wData = '0;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [DW-1:0] rData;
  logic [4:0]    level;

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush), .wEn(wEn), .wData(wData),
    .full(full), .almost_full(almost_full), .rEn(rEn), .rData(rData),
    .empty(empty), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fl, we, re, ce;
    logic [31:0] wd;
    int          lvl;
    bit          ov, uf, chk;
    logic [31:0] rd;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit fl, bit we, bit re, bit ce, logic [31:0] wd,
                              int lvl, bit ov, bit uf, bit chk, logic [31:0] rd);
    vec_t v;
    v.fl = fl; v.we = we; v.re = re; v.ce = ce; v.wd = wd;
    v.lvl = lvl; v.ov = ov; v.uf = uf; v.chk = chk; v.rd = rd;
    vq.push_back(v);
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, int lvl, bit ov, bit uf, bit chk, logic [31:0] rd);
    cmp({tag, " level"}, 32'(level), 32'(lvl));
    cmp({tag, " empty"}, 32'(empty), 32'(lvl == 0));
    cmp({tag, " full"}, 32'(full), 32'(lvl == DEPTH));
    cmp({tag, " almost_full"}, 32'(almost_full), 32'(lvl >= AFL));
    cmp({tag, " almost_empty"}, 32'(almost_empty), 32'(lvl <= AEL));
    cmp({tag, " overflow"}, 32'(overflow), 32'(ov));
    cmp({tag, " underflow"}, 32'(underflow), 32'(uf));
    if (chk) cmp({tag, " rData"}, rData, rd);
  endtask

  task automatic drive(bit fl, bit we, bit re, bit ce, logic [31:0] wd);
    flush = fl; wEn = we; rEn = re; clr_err = ce; wData = wd;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  int          mq[$];
  bit          m_ov, m_uf;

  initial begin
    // Test-plan sequence expressed as vectors; expectations follow the FIFO rules directly.
    for (int n = 1; n <= DEPTH; n++) add(0, 1, 0, 0, n - 1, n, 0, 0, 1, 0);
    add(0, 1, 0, 0, 99, 16, 1, 0, 1, 0);
    add(0, 1, 0, 1, 77, 16, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 16, 0, 0, 1, 0);
    for (int j = 0; j < 4; j++) add(0, 1, 1, 0, 16 + j, 16, 0, 0, 1, j + 1);
    for (int k = 1; k <= DEPTH; k++) add(0, 0, 1, 0, 0, 16 - k, 0, 0, k < DEPTH, 4 + k);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 32'hA5, 1, 0, 1, 1, 32'hA5);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1, 32'hA5);
    for (int n = 1; n <= 4; n++) add(0, 1, 0, 0, n, n + 1, 0, 0, 1, 32'hA5);
    add(1, 1, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 32'h55, 1, 0, 0, 1, 32'h55);

    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    #3;

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].we, vq[i].re, vq[i].ce, vq[i].wd);
      cycle();
      check_all($sformatf("vec%0d", i), vq[i].lvl, vq[i].ov, vq[i].uf, vq[i].chk, vq[i].rd);
    end

    // Underflow, refill to 9 words, then asynchronous reset mid-stream.
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0); cycle();
    for (int n = 0; n < 9; n++) begin
      drive(0, 1, 0, 0, 32'h100 + n); cycle();
    end
    drive(0, 0, 0, 0, 0);
    check_all("pre_rst", 9, 0, 1, 1, 32'h100);
    arst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    #1;
    arst_n = 1'b1;
    cycle();
    check_all("post_rst", 0, 0, 0, 0, 0);

    // Randomized traffic against a queue model, alternating fill- and drain-biased phases.
    m_ov = 0; m_uf = 0;
    for (int i = 0; i < 3000; i++) begin
      bit fl, we, re, ce, ra, wa;
      logic [31:0] wd;
      fl = ($urandom_range(63) == 0);
      ce = ($urandom_range(15) == 0);
      we = ($urandom_range(99) < (((i / 200) % 2) ? 30 : 80));
      re = ($urandom_range(99) < (((i / 200) % 2) ? 80 : 30));
      wd = $urandom;
      drive(fl, we, re, ce, wd);
      if (fl) begin
        mq.delete();
        if (ce) begin m_ov = 0; m_uf = 0; end
      end else begin
        ra = re && (mq.size() > 0);
        wa = we && ((mq.size() < DEPTH) || ra);
        m_ov = (we && !wa) ? 1'b1 : (ce ? 1'b0 : m_ov);
        m_uf = (re && mq.size() == 0) ? 1'b1 : (ce ? 1'b0 : m_uf);
        if (ra) void'(mq.pop_front());
        if (wa) mq.push_back(int'(wd));
      end
      cycle();
      check_all($sformatf("rnd%0d", i), mq.size(), m_ov, m_uf, mq.size() > 0,
                mq.size() > 0 ? 32'(mq[0]) : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
